// File: rtl/mpmc11_strip_ctrl_if.sv
// Command and read-data bundle between the strip engine (master) and the MIG
// user interface (slave).
interface mpmc11_strip_ctrl_if #(
  parameter int AW = 29,
  parameter int DW = 128
);
  logic          app_rdy;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rd_data_valid;
  logic [DW-1:0] app_rd_data;

  modport master (
    input  app_rdy, app_rd_data_valid, app_rd_data,
    output app_en, app_cmd, app_addr
  );

  modport slave (
    output app_rdy, app_rd_data_valid, app_rd_data,
    input  app_en, app_cmd, app_addr
  );
endinterface

// File: rtl/mpmc11_strip_ctrl.sv
// Read-strip engine: issues num_strips+1 READs to the MIG and packs the returned
// strips into a line buffer. Optional response watchdog: MPMC11_STRIP_TIMEOUT_EN.
module mpmc11_strip_ctrl #(
  parameter int DW          = 128,
  parameter int AW          = 29,
  parameter int ADDR_INC    = 8,
  parameter int LINE_STRIPS = 4,
  parameter int TO_LIMIT    = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [AW-1:0]             base_adr,
  input  logic [5:0]                num_strips,
  mpmc11_strip_ctrl_if.master       mig,
  output logic [5:0]                req_strip_cnt,
  output logic [5:0]                resp_strip_cnt,
  output logic                      busy,
  output logic                      done,
  output logic [DW*LINE_STRIPS-1:0] line_o,
  output logic                      stray,
  output logic                      err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [5:0]    r_num;
  logic [5:0]    r_req;
  logic [5:0]    r_resp;
  logic [AW-1:0] r_base;
  logic          r_stray;
  logic          w_start;
  logic          w_active;
  logic          w_accept;
  logic          w_last_cmd;
  logic          w_cap;
  logic          w_last_resp;
  logic          w_timeout;
  logic [AW-1:0] w_addr;

  assign w_start     = (r_state == S_IDLE) && start;
  assign w_active    = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_accept    = (r_state == S_ISSUE) && mig.app_rdy;
  assign w_last_cmd  = w_accept && (r_req == r_num);
  assign w_cap       = w_active && mig.app_rd_data_valid;
  assign w_last_resp = w_cap && (r_resp == r_num);
  // Address arithmetic is deliberately modulo 2^AW.
  assign w_addr      = r_base + ({{(AW-6){1'b0}}, r_req} * AW'(ADDR_INC));

  assign mig.app_en   = (r_state == S_ISSUE);
  assign mig.app_cmd  = mig.app_en ? 3'b001 : 3'b000;
  assign mig.app_addr = mig.app_en ? w_addr : '0;

  assign req_strip_cnt  = r_req;
  assign resp_strip_cnt = r_resp;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign stray          = r_stray;

`ifdef MPMC11_STRIP_TIMEOUT_EN
  logic [7:0] r_wdog;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_wdog <= '0;
    else if (w_start || mig.app_rd_data_valid)
      r_wdog <= '0;
    else if (w_active)
      r_wdog <= r_wdog + 8'd1;
  end

  assign w_timeout = w_active && (r_wdog == 8'(TO_LIMIT));
`else
  assign w_timeout = 1'b0;
`endif
  assign err = w_timeout;

  // The final response wins over both the timeout and the final command acceptance.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_ISSUE;
      S_ISSUE: begin
        if (w_last_resp)      w_state_next = S_DONE;
        else if (w_timeout)   w_state_next = S_IDLE;
        else if (w_last_cmd)  w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_last_resp)      w_state_next = S_DONE;
        else if (w_timeout)   w_state_next = S_IDLE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_num   <= '0;
      r_base  <= '0;
      r_req   <= '0;
      r_resp  <= '0;
      r_stray <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_stray <= (r_state == S_IDLE) && mig.app_rd_data_valid;
      if (w_start) begin
        r_num  <= num_strips;
        r_base <= base_adr;
        r_req  <= '0;
        r_resp <= '0;
      end else begin
        // Both counters stop at num_strips, so 64 strips never overflow 6 bits.
        if (w_accept && !w_last_cmd) r_req  <= r_req + 6'd1;
        if (w_cap && !w_last_resp)   r_resp <= r_resp + 6'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINE_STRIPS; gi++) begin : g_slot
      logic [DW-1:0] r_slot;

      always_ff @(posedge clk) begin
        if (!rst_n)
          r_slot <= '0;
        else if (w_cap && (r_resp == 6'(gi)))
          r_slot <= mig.app_rd_data;
      end

      assign line_o[gi*DW +: DW] = r_slot;
    end
  endgenerate
endmodule

// File: tb/tb_mpmc11_strip_ctrl.sv
// Randomized self-checking bench for mpmc11_strip_ctrl; a small MIG responder
// returns data in order after a configurable latency.
`timescale 1ns/1ps
module tb_mpmc11_strip_ctrl;
  localparam int AW = 29;
  localparam int DW = 128;
  localparam int LS = 4;
  localparam int LW = DW*LS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_adr = '0;
  logic [5:0]    num_strips = '0;
  logic [5:0]    req_strip_cnt;
  logic [5:0]    resp_strip_cnt;
  logic          busy;
  logic          done;
  logic          stray;
  logic          err;
  logic [LW-1:0] line_o;

  int checks = 0;
  int errors = 0;
  logic [LW-1:0] m_line = '0;
  logic [5:0]    m_req = '0;
  logic [5:0]    m_resp = '0;

  mpmc11_strip_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  mpmc11_strip_ctrl #(
    .DW(DW), .AW(AW), .ADDR_INC(8), .LINE_STRIPS(LS), .TO_LIMIT(255)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_adr(base_adr),
    .num_strips(num_strips),
    .mig(bus),
    .req_strip_cnt(req_strip_cnt),
    .resp_strip_cnt(resp_strip_cnt),
    .busy(busy),
    .done(done),
    .line_o(line_o),
    .stray(stray),
    .err(err)
  );

  always #5 clk = ~clk;

  // One complete request: commands expected at b + i*8 (mod 2^AW) in order,
  // response i returned lat cycles after command i is accepted.
  task automatic run_req(input logic [AW-1:0] b, input int n, input int rdy_pct,
                         input int lat, input int stall_len, input string name);
    int due[$];
    int acc = 0, sent = 0, done_cnt = 0, done_c = -1, last_c = -1, en_cycles = 0;
    int stall = stall_len;
    bit fin = 0;
    bit rdy;
    logic [AW-1:0] ea;
    logic [DW-1:0] d;
    @(negedge clk);
    start = 1'b1; base_adr = b; num_strips = 6'(n);
    @(negedge clk);
    start = 1'b0; base_adr = AW'($urandom); num_strips = 6'($urandom);
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      ea = b + AW'(acc*8);
      checks++;
      if (bus.app_en !== (acc <= n)) begin
        errors++;
        $display("FAIL %s app_en: got %b required %b after %0d accepted", name, bus.app_en, (acc <= n), acc);
      end
      if (bus.app_en === 1'b1) begin
        en_cycles++;
        checks++;
        if (bus.app_cmd !== 3'b001 || bus.app_addr !== ea) begin
          errors++;
          $display("FAIL %s command: got cmd=%b addr=%h required cmd=001 addr=%h", name, bus.app_cmd, bus.app_addr, ea);
        end
      end else begin
        checks++;
        if (bus.app_cmd !== 3'b000) begin
          errors++;
          $display("FAIL %s idle cmd: got %b required 000", name, bus.app_cmd);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
        checks++;
        if (req_strip_cnt !== 6'(n) || resp_strip_cnt !== 6'(n) || busy !== 1'b1 || c != last_c + 1) begin
          errors++;
          $display("FAIL %s done: req=%0d resp=%0d busy=%b cycle=%0d required req=resp=%0d busy=1 cycle=%0d",
                   name, req_strip_cnt, resp_strip_cnt, busy, c, n, last_c + 1);
        end
      end
      if (done_cnt > 0 && c > done_c) begin
        fin = 1;
        checks++;
        if (busy !== 1'b0 || done_cnt != 1) begin
          errors++;
          $display("FAIL %s end: busy=%b done_pulses=%0d required busy=0 done_pulses=1", name, busy, done_cnt);
        end
      end
      if (!fin) begin
        if (stall > 0 && acc == 1) begin
          rdy = 1'b0;
          stall--;
        end else begin
          rdy = ($urandom_range(99) < rdy_pct);
        end
        bus.app_rdy = rdy;
        if (bus.app_en === 1'b1 && rdy) begin
          due.push_back(c + lat);
          acc++;
        end
        bus.app_rd_data_valid = 1'b0;
        bus.app_rd_data = {$urandom, $urandom, $urandom, $urandom};
        if (due.size() > 0 && due[0] == c) begin
          void'(due.pop_front());
          d = {$urandom, $urandom, $urandom, $urandom};
          bus.app_rd_data_valid = 1'b1;
          bus.app_rd_data = d;
          if (sent < LS) m_line[sent*DW +: DW] = d;
          sent++;
          last_c = c;
        end
      end
    end
    bus.app_rdy = 1'b0;
    bus.app_rd_data_valid = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s budget: request did not complete within 3000 cycles", name);
    end
    checks++;
    if (acc != n + 1 || sent != n + 1) begin
      errors++;
      $display("FAIL %s strips: accepted=%0d returned=%0d required %0d", name, acc, sent, n + 1);
    end
    checks++;
    if (line_o !== m_line) begin
      errors++;
      $display("FAIL %s line_o: got %h required %h", name, line_o, m_line);
    end
    if (rdy_pct == 100) begin
      checks++;
      if (en_cycles != n + 1 + stall_len) begin
        errors++;
        $display("FAIL %s en_cycles: got %0d required %0d", name, en_cycles, n + 1 + stall_len);
      end
    end
    m_req = 6'(n);
    m_resp = 6'(n);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.app_en !== 1'b0 || bus.app_cmd !== 3'b000 || bus.app_addr !== '0 ||
        req_strip_cnt !== 6'd0 || resp_strip_cnt !== 6'd0 || busy !== 1'b0 ||
        done !== 1'b0 || stray !== 1'b0 || err !== 1'b0 || line_o !== '0) begin
      errors++;
      $display("FAIL reset: en=%b cmd=%b addr=%h req=%0d resp=%0d busy=%b done=%b stray=%b err=%b required all zero",
               bus.app_en, bus.app_cmd, bus.app_addr, req_strip_cnt, resp_strip_cnt, busy, done, stray, err);
    end
    rst_n = 1'b1;
    m_line = '0; m_req = '0; m_resp = '0;
  endtask

  task automatic test_basic;
    run_req(AW'(32'h100), 3, 100, 10, 0, "basic");
  endtask

  task automatic test_backpressure;
    run_req(AW'($urandom), 3, 100, 2, 5, "backpressure");
  endtask

  task automatic test_early_resp;
    run_req(AW'($urandom), 0, 100, 0, 0, "early_resp");
  endtask

  task automatic test_long_burst;
    run_req(AW'($urandom), 5, 100, 3, 0, "long_burst");
  endtask

  task automatic test_wrap;
    run_req({AW{1'b1}} - AW'(15), 4, 70, 1, 0, "addr_wrap");
  endtask

  task automatic test_stray;
    @(negedge clk);
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL stray idle: got %b required 0", stray);
    end
    bus.app_rd_data_valid = 1'b1;
    bus.app_rd_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.app_rd_data_valid = 1'b0;
    checks++;
    if (stray !== 1'b1 || req_strip_cnt !== m_req || resp_strip_cnt !== m_resp ||
        line_o !== m_line || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray pulse: stray=%b req=%0d resp=%0d busy=%b required stray=1 req=%0d resp=%0d busy=0 line unchanged",
               stray, req_strip_cnt, resp_strip_cnt, busy, m_req, m_resp);
    end
    @(negedge clk);
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL stray width: got %b required 0", stray);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; base_adr = AW'($urandom); num_strips = 6'd7;
    bus.app_rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.app_rdy = 1'b0;
    checks++;
    if (bus.app_en !== 1'b0 || busy !== 1'b0 || req_strip_cnt !== 6'd0 ||
        resp_strip_cnt !== 6'd0 || done !== 1'b0 || line_o !== '0) begin
      errors++;
      $display("FAIL reset_mid: en=%b busy=%b req=%0d resp=%0d done=%b required all zero",
               bus.app_en, busy, req_strip_cnt, resp_strip_cnt, done);
    end
    m_line = '0; m_req = '0; m_resp = '0;
  endtask

  task automatic test_back_to_back;
    int n;
    for (int i = 0; i < 12; i++) begin
      n = ($urandom_range(5) == 0) ? 63 : int'($urandom_range(9));
      run_req(AW'($urandom), n, 30 + int'($urandom_range(70)), int'($urandom_range(12)), 0, "random");
    end
  endtask

  task automatic test_timeout;
    int err_first = -1, err_cnt = 0, done_cnt = 0;
    int exp_first, exp_cnt;
    logic exp_busy;
`ifdef MPMC11_STRIP_TIMEOUT_EN
    exp_first = 256; exp_cnt = 1; exp_busy = 1'b0;
`else
    exp_first = -1; exp_cnt = 0; exp_busy = 1'b1;
`endif
    @(negedge clk);
    start = 1'b1; base_adr = AW'($urandom); num_strips = 6'd2;
    bus.app_rdy = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (err === 1'b1) begin
        err_cnt++;
        if (err_first < 0) err_first = k;
      end
      if (done === 1'b1) done_cnt++;
    end
    bus.app_rdy = 1'b0;
    checks++;
    if (err_first != exp_first || err_cnt != exp_cnt) begin
      errors++;
      $display("FAIL timeout err: first=%0d pulses=%0d required first=%0d pulses=%0d", err_first, err_cnt, exp_first, exp_cnt);
    end
    checks++;
    if (done_cnt != 0 || busy !== exp_busy) begin
      errors++;
      $display("FAIL timeout state: done_pulses=%0d busy=%b required done_pulses=0 busy=%b", done_cnt, busy, exp_busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_line = '0; m_req = '0; m_resp = '0;
  endtask

  initial begin
    bus.app_rdy = 1'b0;
    bus.app_rd_data_valid = 1'b0;
    bus.app_rd_data = '0;
    test_reset;
    test_basic;
    test_backpressure;
    test_early_resp;
    test_long_burst;
    test_stray;
    test_reset_mid;
    test_stray;
    test_wrap;
    test_back_to_back;
    test_timeout;
    test_basic;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mpmc11_strip_ctrl.md
Name: mpmc11_strip_ctrl

Overview:
- Read-strip engine that sits between the mpmc11 controller state machine and the MIG user interface.
- For one read request it issues num_strips+1 consecutive READ commands to the MIG. It counts the responses that come back and packs the returned strips into one line buffer.
- Its outputs req_strip_cnt and resp_strip_cnt drive the controller state machine's READ_DATA1/READ_DATA2 exit conditions directly. The state machine uses done to leave READ_DATA2.

Parameters:
- DW, 128: MIG app data width per strip (bits).
- AW, 29: MIG app address width.
- ADDR_INC, 8: address increment between strips (MIG column units).
- LINE_STRIPS, 4: number of strips held in the line buffer.
- TO_LIMIT, 255: response watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- base_adr  in  AW  address of strip 0.
- num_strips  in  6  index of the last strip; total strips issued = num_strips+1.
- app_rdy  in  1  MIG command ready.
- app_en  out  1  MIG command enable.
- app_cmd  out  3  MIG command; 3'b001 (READ) whenever app_en=1, else 3'b000.
- app_addr  out  AW  MIG command address.
- app_rd_data_valid  in  1  MIG read data strobe.
- app_rd_data  in  DW  MIG read data.
- req_strip_cnt  out  6  count of accepted commands (index of the next strip to issue).
- resp_strip_cnt  out  6  count of received strips.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when all strips have been received.
- line_o  out  DW*LINE_STRIPS  assembled line; strip i occupies bits [i*DW +: DW].
- stray  out  1  one-cycle pulse when app_rd_data_valid arrives while in IDLE.
- err  out  1  one-cycle timeout pulse (only with the optional feature; tied to 0 otherwise).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs become 0, including line_o, both counters, app_addr and app_cmd.
  - Reset mid-operation aborts immediately. No further app_en is driven, and pending responses are later reported as stray.
- States: IDLE, ISSUE, WAIT_RESP, DONE.
- IDLE:
  - start=1 latches num_strips and base_adr, clears both counters, and moves to ISSUE on the next cycle.
  - line_o keeps its previous value until the first response of the new request overwrites it.
- ISSUE:
  - app_en=1 and app_addr = base_adr + req_strip_cnt*ADDR_INC, computed modulo 2^AW (wraps, no error).
  - A command is accepted on a cycle where app_en && app_rdy.
  - On acceptance with req_strip_cnt != num_strips: req_strip_cnt increments.
  - On acceptance with req_strip_cnt == num_strips: req_strip_cnt holds (it equals num_strips, as the controller expects), app_en drops the next cycle, and the state moves to WAIT_RESP.
  - app_en remains asserted and app_addr remains stable while app_rdy=0.
- Response capture, active in ISSUE, WAIT_RESP and DONE-entry:
  - On each app_rd_data_valid, if resp_strip_cnt < LINE_STRIPS, app_rd_data is written to strip slot resp_strip_cnt.
  - Strips at index >= LINE_STRIPS are counted but discarded.
- Completion:
  - A valid arriving with resp_strip_cnt == num_strips is the final strip; the final strip's data is still captured.
  - The next state is DONE, and resp_strip_cnt holds at num_strips.
  - This applies even if it occurs in ISSUE on the same cycle as the final command acceptance. In that case DONE is entered directly.
  - Any other valid increments resp_strip_cnt.
- DONE: done=1 for exactly one cycle, then the state moves to IDLE. start is ignored while in DONE.
- busy=1 in ISSUE, WAIT_RESP and DONE.
- Counters are 6-bit. num_strips=63 gives 64 strips with no overflow, because the counters stop at num_strips.
- A response arriving in IDLE is not captured and no counter changes; stray pulses for one cycle.

Optional Feature:
- Macro: MPMC11_STRIP_TIMEOUT_EN.
- When defined:
  - An 8-bit watchdog counter clears on start and on every app_rd_data_valid, and increments in ISSUE and WAIT_RESP.
  - When it reaches TO_LIMIT, err pulses for one cycle and the state returns to IDLE without a done pulse.
  - The counters hold their values for debug.
- When undefined: no watchdog logic is present, err is constant 0, and WAIT_RESP waits indefinitely.

Test Plan:
- Basic read:
  - Stimulus: base_adr=0x100, num_strips=3, app_rdy=1, responses D0..D3 starting 10 cycles after the first command.
  - Required: app_en is high for 4 cycles with addresses 0x100, 0x108, 0x110, 0x118; req_strip_cnt reaches 3; line_o = {D3,D2,D1,D0}; done pulses once on the cycle after D3.
- Command backpressure:
  - Stimulus: app_rdy=0 for 5 cycles on strip 1.
  - Required: app_addr stays at base+8 with app_en=1 throughout; no strip is skipped or duplicated.
- Early responses during ISSUE:
  - Stimulus: app_rd_data_valid asserted concurrently with the final command acceptance, with num_strips=0.
  - Required: the state goes directly to DONE; done pulses one cycle later; resp_strip_cnt=0.
- Long burst:
  - Stimulus: num_strips=5 with LINE_STRIPS=4.
  - Required: slots 0-3 hold D0-D3; D4 and D5 are discarded; resp_strip_cnt ends at 5; done pulses exactly once.
- Stray data and reset:
  - Stimulus A: valid asserted in IDLE. Required: stray=1 for one cycle and counters unchanged.
  - Stimulus B: rst_n=0 mid-ISSUE. Required: next cycle app_en=0, busy=0, req_strip_cnt=0.
- Timeout (MPMC11_STRIP_TIMEOUT_EN defined, TO_LIMIT=255):
  - Stimulus: no responses after the commands.
  - Required: err pulses 255 cycles after the last counter clear; state returns to IDLE; done is never asserted.
